// File: rtl/regfile_port_arbiter.sv
// Shares register-file port B between the CPU and the debug interface.
// Grants are combinational; read data and debug write errors come back one cycle after the grant.
module regfile_port_arbiter #(
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter bit          PROTECT_SPECIAL = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable_i,
  input  logic       cpu_req_i,
  input  logic       cpu_we_i,
  input  logic [4:0] cpu_addr_i,
  input  logic [7:0] cpu_wdata_i,
  output logic       cpu_gnt_o,
  output logic       cpu_rvalid_o,
  output logic [7:0] cpu_rdata_o,
  input  logic       dbg_req_i,
  input  logic       dbg_we_i,
  input  logic [4:0] dbg_addr_i,
  input  logic [7:0] dbg_wdata_i,
  output logic       dbg_gnt_o,
  output logic       dbg_rvalid_o,
  output logic [7:0] dbg_rdata_o,
  output logic       dbg_err_o,
  output logic       rf_enable_o,
  output logic [4:0] rf_b_addr_o,
  output logic [7:0] rf_b_data_in_o,
  output logic       rf_b_wr_enable_o,
  input  logic [7:0] rf_b_data_out_i
);

  localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);
  localparam logic [4:0] SPECIAL_LOW = 5'd29;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       cpu_rvalid_q, dbg_rvalid_q, dbg_err_q;
  logic [7:0] cpu_rdata_q, dbg_rdata_q;

  logic active, starve_hit, cpu_win, dbg_win, reject;

  always_comb begin
    active     = enable_i & resetn;
    // Debug only overrides the CPU once it has waited out the full limit.
    starve_hit = dbg_req_i & (starve_cnt_q == LIMIT);
    cpu_win    = active & cpu_req_i & ~starve_hit;
    dbg_win    = active & dbg_req_i & ~cpu_win;
    reject     = dbg_win & dbg_we_i & PROTECT_SPECIAL & (dbg_addr_i >= SPECIAL_LOW);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (enable_i) begin
      if (dbg_win || !dbg_req_i) begin
        starve_cnt_d = 4'd0;
      end else if (cpu_win && (starve_cnt_q < LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      cpu_rdata_q  <= 8'h00;
      dbg_rdata_q  <= 8'h00;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_win & ~cpu_we_i;
      dbg_rvalid_q <= dbg_win & ~dbg_we_i;
      dbg_err_q    <= reject;
      if (cpu_win && !cpu_we_i) cpu_rdata_q <= rf_b_data_out_i;
      if (dbg_win && !dbg_we_i) dbg_rdata_q <= rf_b_data_out_i;
    end
  end

  assign cpu_gnt_o        = cpu_win;
  assign dbg_gnt_o        = dbg_win;
  assign cpu_rvalid_o     = cpu_rvalid_q;
  assign cpu_rdata_o      = cpu_rdata_q;
  assign dbg_rvalid_o     = dbg_rvalid_q;
  assign dbg_rdata_o      = dbg_rdata_q;
  assign dbg_err_o        = dbg_err_q;
  assign rf_enable_o      = enable_i;
  assign rf_b_addr_o      = dbg_win ? dbg_addr_i  : cpu_addr_i;
  assign rf_b_data_in_o   = dbg_win ? dbg_wdata_i : cpu_wdata_i;
  assign rf_b_wr_enable_o = (cpu_win & cpu_we_i) | (dbg_win & dbg_we_i & ~reject);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Randomised and directed bench for regfile_port_arbiter with a queue scoreboard.
module tb_regfile_port_arbiter;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0] dbg_addr = '0;
  logic [7:0] dbg_wdata = '0;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, dbg_err;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       rf_enable, rf_b_wr_enable;
  logic [4:0] rf_b_addr;
  logic [7:0] rf_b_data_in, rf_b_data_out;

  always #5 clk = ~clk;

  regfile_port_arbiter #(.STARVE_LIMIT(LIMIT), .PROTECT_SPECIAL(1'b1)) dut (
    .clk(clk), .resetn(resetn), .enable_i(enable),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .dbg_err_o(dbg_err), .rf_enable_o(rf_enable),
    .rf_b_addr_o(rf_b_addr), .rf_b_data_in_o(rf_b_data_in),
    .rf_b_wr_enable_o(rf_b_wr_enable), .rf_b_data_out_i(rf_b_data_out)
  );

  // Register file attached to the DUT (async read, write at posedge).
  logic [7:0] rf_mem [32];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 8'h00;
    end else if (rf_enable && rf_b_wr_enable) begin
      rf_mem[rf_b_addr] <= rf_b_data_in;
    end
  end
  assign rf_b_data_out = rf_mem[rf_b_addr];

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t       cpu_q[$], dbg_q[$];
  int         err_q[$];
  int         n_checks = 0, n_fail = 0;
  int         cyc = 0;
  logic [7:0] model_mem [32];
  int         model_starve = 0;
  logic [7:0] last_cpu = 8'h00, last_dbg = 8'h00;
  logic       last_cw, last_dw;
  string      glog;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_log(input string name, input string exp);
    n_checks++;
    if (glog != exp) begin
      n_fail++;
      $display("FAIL %s: grant sequence %s, expected %s", name, glog, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a completion.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 0);
      else begin
        e = cpu_q.pop_front();
        check("cpu_rvalid_cycle", cyc, e.due);
        check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
        last_cpu = e.data;
      end
    end else begin
      check("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_cpu));
      if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
        check("cpu_rvalid_missing", 32'(cpu_rvalid), 1);
        void'(cpu_q.pop_front());
      end
    end
    if (dbg_rvalid) begin
      if (dbg_q.size() == 0) check("dbg_rvalid_unexpected", 32'(dbg_rvalid), 0);
      else begin
        e = dbg_q.pop_front();
        check("dbg_rvalid_cycle", cyc, e.due);
        check("dbg_rdata", 32'(dbg_rdata), 32'(e.data));
        last_dbg = e.data;
      end
    end else begin
      check("dbg_rdata_hold", 32'(dbg_rdata), 32'(last_dbg));
      if (dbg_q.size() > 0 && dbg_q[0].due <= cyc) begin
        check("dbg_rvalid_missing", 32'(dbg_rvalid), 1);
        void'(dbg_q.pop_front());
      end
    end
    if (dbg_err) begin
      if (err_q.size() == 0) check("dbg_err_unexpected", 32'(dbg_err), 0);
      else check("dbg_err_cycle", cyc, err_q.pop_front());
    end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
      check("dbg_err_missing", 32'(dbg_err), 1);
      void'(err_q.pop_front());
    end
  end

  // One bus cycle: predict from the model, check grants mid-cycle, advance past the edge.
  task automatic step();
    logic cw, dw, rej, we_exp;
    bit   active;
    active = enable && resetn;
    cw  = active && cpu_req && !(dbg_req && model_starve == LIMIT);
    dw  = active && dbg_req && !cw;
    rej = dw && dbg_we && (dbg_addr >= 5'd29);
    we_exp = (cw && cpu_we) || (dw && dbg_we && !rej);
    if (cw) begin
      if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
      else cpu_q.push_back('{cyc + 1, model_mem[cpu_addr]});
    end
    if (dw) begin
      if (!dbg_we) dbg_q.push_back('{cyc + 1, model_mem[dbg_addr]});
      else if (rej) err_q.push_back(cyc + 1);
      else model_mem[dbg_addr] = dbg_wdata;
    end
    if (!resetn) model_starve = 0;
    else if (enable) begin
      if (dw || !dbg_req) model_starve = 0;
      else if (cw && model_starve < LIMIT) model_starve++;
    end
    @(negedge clk);
    check("cpu_gnt", 32'(cpu_gnt), 32'(cw));
    check("dbg_gnt", 32'(dbg_gnt), 32'(dw));
    check("rf_b_wr_enable", 32'(rf_b_wr_enable), 32'(we_exp));
    check("rf_enable", 32'(rf_enable), 32'(enable));
    glog = {glog, cw ? "C" : (dw ? "D" : "-")};
    last_cw = cw;
    last_dw = dw;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [4:0] a, input logic [7:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [4:0] a, input logic [7:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    model_starve = 0;
    cpu_q.delete();
    dbg_q.delete();
    err_q.delete();
    last_cpu = 8'h00;
    last_dbg = 8'h00;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    @(posedge clk);
    #1;
    // Reset with both requesters active.
    enable = 1'b1;
    set_cpu(1, 0, 5'd1, 8'h00);
    set_dbg(1, 0, 5'd2, 8'h00);
    do_reset();
    check("reset_cpu_rdata", 32'(cpu_rdata), 0);
    check("reset_dbg_rdata", 32'(dbg_rdata), 0);
    check("reset_dbg_err", 32'(dbg_err), 0);

    // CPU write then read-after-write.
    set_dbg(0, 0, 5'd0, 8'h00);
    set_cpu(1, 1, 5'd5, 8'hA5); step();
    set_cpu(1, 0, 5'd5, 8'h00); step();
    set_cpu(0, 0, 5'd0, 8'h00); step();
    check("raw_cpu_rdata", 32'(cpu_rdata), 32'h A5);

    // Starvation pattern with both requesting continuously.
    set_cpu(1, 1, 5'd30, 8'h77); step();
    set_cpu(1, 0, 5'd5, 8'h00);
    set_dbg(1, 0, 5'd30, 8'h00);
    glog = "";
    for (int i = 0; i < 10; i++) step();
    check_log("starve_pattern", "CCCCDCCCCD");

    // Debug write to a protected register is consumed but rejected.
    set_cpu(0, 0, 5'd0, 8'h00);
    set_dbg(1, 1, 5'd30, 8'h3C); step();
    check("protect_err_pulse", 32'(dbg_err), 1);
    set_dbg(1, 0, 5'd30, 8'h00); step();
    set_dbg(0, 0, 5'd0, 8'h00); step();
    check("protect_read_prior", 32'(dbg_rdata), 32'h77);
    set_dbg(1, 1, 5'd28, 8'h3C); step();
    set_dbg(1, 0, 5'd28, 8'h00); step();
    set_dbg(0, 0, 5'd0, 8'h00); step();
    check("unprotected_write", 32'(dbg_rdata), 32'h3C);

    // Enable low holds arbitration and the starvation count.
    set_cpu(1, 0, 5'd5, 8'h00);
    set_dbg(1, 0, 5'd28, 8'h00);
    glog = "";
    step(); step();
    enable = 1'b0;
    step(); step(); step();
    enable = 1'b1;
    step(); step(); step();
    check_log("enable_hold", "CC---CCD");

    // Reset the cycle after a CPU read grant.
    set_dbg(0, 0, 5'd0, 8'h00);
    set_cpu(1, 0, 5'd5, 8'h00); step();
    set_dbg(1, 0, 5'd1, 8'h00);
    do_reset();
    glog = "";
    step();
    check_log("post_reset_first", "C");

    // Randomised traffic with requesters that hold until granted.
    set_cpu(0, 0, 5'd0, 8'h00);
    set_dbg(0, 0, 5'd0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      if (!cpu_req && $urandom_range(0, 3) != 0)
        set_cpu(1, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 1) ? $urandom_range(26, 31) : $urandom_range(0, 7)),
                8'($urandom));
      if (!dbg_req && $urandom_range(0, 2) != 0)
        set_dbg(1, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 1) ? $urandom_range(26, 31) : $urandom_range(0, 7)),
                8'($urandom));
      enable = ($urandom_range(0, 9) != 0);
      step();
      if (last_cw) cpu_req = 1'b0;
      if (last_dw) dbg_req = 1'b0;
      if ($urandom_range(0, 499) == 0) begin
        set_cpu(0, 0, 5'd0, 8'h00);
        set_dbg(0, 0, 5'd0, 8'h00);
        do_reset();
      end
    end

    enable = 1'b1;
    set_cpu(0, 0, 5'd0, 8'h00);
    set_dbg(0, 0, 5'd0, 8'h00);
    step(); step(); step();
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("dbg_queue_drained", dbg_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Two-requester arbiter for port B (read/write) of the CPU's 32 x 8-bit register file. Shares the port between the CPU core (normal priority owner) and the debug/host interface. Uses a starvation counter to guarantee debug forward progress, blocks debug writes to the special registers (GOUT=29, DOUT=30, FLAG=31), and returns read data one cycle after grant. Port A of the register file is not touched by this block.

## Interface
- STARVE_LIMIT, default 4: consecutive CPU grants allowed while debug waits; legal range 1..15.
- PROTECT_SPECIAL, default 1: 1 = debug writes to addresses 29..31 are rejected.
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- enable  in  1  global run enable; 0 = no grants, no writes.
- cpu_req / cpu_we  in  1 / 1  CPU request valid; 1 = write.
- cpu_addr / cpu_wdata  in  5 / 8  CPU address and write data.
- cpu_gnt  out  1  combinational; the request is accepted this cycle.
- cpu_rvalid / cpu_rdata  out  1 / 8  read completion, one cycle after a read grant.
- dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/5/8  debug request, same meaning as the CPU request.
- dbg_gnt  out  1  combinational accept.
- dbg_rvalid / dbg_rdata  out  1 / 8  debug read completion.
- dbg_err  out  1  one-cycle pulse: a debug write was rejected.
- rf_enable  out  1  enable for the register file; equals enable.
- rf_b_addr / rf_b_data_in / rf_b_wr_enable  out  5/8/1  register file port B drive.
- rf_b_data_out  in  8  register file port B read data.

## Operation
- Each cycle at most one grant.
  - Winner is CPU if cpu_req, unless (dbg_req and starve_cnt == STARVE_LIMIT); otherwise debug if dbg_req.
  - No grant when enable = 0 or resetn = 0.
- starve_cnt, width 4:
  - Increments on a CPU grant while dbg_req = 1.
  - Clears on any debug grant, or on any enable cycle with dbg_req = 0.
  - Holds while enable = 0; saturates at STARVE_LIMIT.
- Port drive:
  - rf_b_addr and rf_b_data_in are muxed from the winner; they default to the CPU fields when there is no grant.
  - rf_b_wr_enable = grant & winner_we & ~reject.
- reject = debug winner & dbg_we & PROTECT_SPECIAL & (dbg_addr >= 29).
  - A rejected write is still granted (consumed).
  - No register file write occurs; dbg_err pulses the next cycle.
- Debug reads of 29..31 are always allowed.
- Reads: at the posedge ending the grant cycle, rf_b_data_out is captured into the winner's rdata. The winner's rvalid = 1 for exactly the next cycle.
- Writes never produce rvalid.
- rdata holds its last value when rvalid = 0.
- Requester rule: hold req and fields stable until gnt. A new request may be presented in the cycle after gnt, giving back-to-back issue of 1 transaction per cycle.

## Timing
- Reset values: cpu_rvalid = 0, dbg_rvalid = 0, cpu_rdata = 0x00, dbg_rdata = 0x00, dbg_err = 0, starve_cnt = 0.
- While resetn = 0: cpu_gnt, dbg_gnt and rf_b_wr_enable are 0.
- Grant: same cycle as req (combinational from req and the registered starve_cnt).
- Write takes effect at the posedge ending the grant cycle.
- Read latency: rvalid and rdata at cycle N+1 for a grant at cycle N.
- Write at N, read of the same address at N+1: rdata at N+2 = newly written value.
- enable dropped: requests wait; rvalid for a grant already made still appears the next cycle.
- Reset asserted mid-transaction: pending rvalid and dbg_err are cleared and never delivered; the register file is cleared by its own reset.
- Both requests present with starve_cnt < STARVE_LIMIT: CPU wins.
- Both requests present with starve_cnt == STARVE_LIMIT: debug wins and starve_cnt resets to 0.

## Test plan
- Reset: assert resetn = 0 with both req = 1 -> all gnt = 0, all rvalid = 0, rdata = 0x00, rf_b_wr_enable = 0.
- CPU write addr 5 = 0xA5 at N, CPU read addr 5 at N+1 -> cpu_gnt both cycles; cpu_rvalid = 1 at N+2 with cpu_rdata = 0xA5.
- Both req continuously, STARVE_LIMIT = 4 -> grant sequence C,C,C,C,D,C,C,C,C,D; each debug read returns its rvalid the following cycle.
- Debug write addr 30 = 0x3C -> dbg_gnt = 1, rf_b_wr_enable = 0, dbg_err pulses 1 cycle; debug read addr 30 returns the prior value; debug write addr 28 = 0x3C succeeds.
- enable = 0 for 3 cycles with both req = 1 -> no gnt, no writes, starve_cnt unchanged; arbitration resumes on the cycle enable = 1.
- resetn pulsed low the cycle after a CPU read grant -> cpu_rvalid never asserts; starve_cnt = 0; first grant after release goes to CPU.
